// File: rtl/runway_dispatch_if.sv
// Runway dispatcher bus: approach-control requests in, runway command code out.
interface runway_dispatch_if;
  logic       req;
  logic       close_a;
  logic       close_b;
  logic       o3;
  logic       o2;
  logic       o1;
  logic       o0;
  logic       en;
  logic [2:0] pending;
  logic       req_ready;
  logic       done;
  logic       drop;

  modport master (
    output req, close_a, close_b,
    input  o3, o2, o1, o0, en, pending, req_ready, done, drop
  );

  modport slave (
    input  req, close_a, close_b,
    output o3, o2, o1, o0, en, pending, req_ready, done, drop
  );
endinterface

// File: rtl/runway_dispatch.sv
// Runway dispatcher: queues landing requests and grants runways A/B round-robin,
// holding each runway code on the bus for HOLD cycles, or WAIT when both are closed.
module runway_dispatch #(
  parameter int unsigned HOLD  = 16,
  parameter int unsigned DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  runway_dispatch_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B, SEND_W} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);
  localparam logic [2:0] DEPTH_C   = 3'(DEPTH);
  localparam logic [3:0] CODE_A    = 4'b1010;
  localparam logic [3:0] CODE_B    = 4'b1011;
  localparam logic [3:0] CODE_W    = 4'b1101;

  state_t     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic [2:0] pending_q, pending_d;
  logic       last_b_q, last_b_d;
  logic       en_q, en_d;
  logic [3:0] code_q, code_d;
  logic       done_q, done_d;
  logic       drop_q, drop_d;
  logic       slot_end;
  logic       full;

  // Prefer the runway not used last if open, else the other, else WAIT.
  function automatic state_t pick(input logic last_b, input logic ca, input logic cb);
    state_t s;
    s = SEND_W;
    if (last_b) begin
      if (!ca)      s = SEND_A;
      else if (!cb) s = SEND_B;
    end else begin
      if (!cb)      s = SEND_B;
      else if (!ca) s = SEND_A;
    end
    return s;
  endfunction

  assign slot_end = ((state_q == SEND_A) || (state_q == SEND_B)) && (hold_q == HOLD_LAST);
  assign full     = (pending_q == DEPTH_C);

  // Queue occupancy: accept, drop, or retire; a req coinciding with a retire cancels out.
  always_comb begin
    pending_d = pending_q;
    drop_d    = 1'b0;
    if (bus.req && !slot_end) begin
      if (full) drop_d    = 1'b1;
      else      pending_d = pending_q + 3'd1;
    end else if (!bus.req && slot_end) begin
      pending_d = pending_q - 3'd1;
    end
  end

  // Next state, hold counter, round-robin flag and registered-output values.
  // An unresolved WAIT falls back to IDLE for one cycle, which yields the 0000 gap
  // and re-enters WAIT (or a runway, if one reopened) on the following edge.
  always_comb begin
    state_d  = state_q;
    hold_d   = '0;
    last_b_d = last_b_q;
    case (state_q)
      IDLE: begin
        if (pending_d != 3'd0) state_d = pick(last_b_q, bus.close_a, bus.close_b);
      end
      SEND_A, SEND_B: begin
        if (slot_end) begin
          last_b_d = (state_q == SEND_B);
          state_d  = (pending_d != 3'd0) ? pick(last_b_d, bus.close_a, bus.close_b) : IDLE;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      SEND_W: begin
        if (!bus.close_a || !bus.close_b) state_d = pick(last_b_q, bus.close_a, bus.close_b);
        else if (hold_q == HOLD_LAST)     state_d = IDLE;
        else                              hold_d  = hold_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase

    en_d = (state_d != IDLE);
    case (state_d)
      SEND_A:  code_d = CODE_A;
      SEND_B:  code_d = CODE_B;
      SEND_W:  code_d = CODE_W;
      default: code_d = '0;
    endcase
    done_d = ((state_d == SEND_A) || (state_d == SEND_B)) && (hold_d == HOLD_LAST);
  end

  // State and registered outputs; reset abandons any slot without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      pending_q <= '0;
      last_b_q  <= 1'b1;
      en_q      <= 1'b0;
      code_q    <= '0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      last_b_q  <= last_b_d;
      en_q      <= en_d;
      code_q    <= code_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  assign {bus.o3, bus.o2, bus.o1, bus.o0} = code_q;
  assign bus.en        = en_q;
  assign bus.pending   = pending_q;
  assign bus.req_ready = (pending_q < DEPTH_C);
  assign bus.done      = done_q;
  assign bus.drop      = drop_q;

endmodule

// File: tb/tb_runway_dispatch.sv
// Directed bench for runway_dispatch (HOLD=16, DEPTH=4).
module tb_runway_dispatch;

  localparam logic [3:0] A = 4'b1010;
  localparam logic [3:0] B = 4'b1011;
  localparam logic [3:0] W = 4'b1101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  runway_dispatch_if bus();

  runway_dispatch #(.HOLD(16), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] code;
  logic [8:0] obs;   // {en, code, pending, done}
  assign code = {bus.o3, bus.o2, bus.o1, bus.o0};
  assign obs  = {bus.en, code, bus.pending, bus.done};

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.req = 1'b0; bus.close_a = 1'b0; bus.close_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; bus.req = 1'b1;
    @(negedge clk);
    checks++;
    if ({obs, bus.drop, bus.req_ready} !== {9'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", {obs, bus.drop, bus.req_ready}, {9'b0, 1'b0, 1'b1});
    end
    rst = 1'b0; bus.req = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 9'b0) begin
      failures++;
      $display("FAIL req_during_rst got=%b exp=%b", obs, 9'b0);
    end
  endtask

  task automatic test_single();
    logic [8:0] exp;
    do_reset();
    bus.req = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      bus.req = 1'b0;
      exp = (c <= 16) ? {1'b1, A, 3'd1, 1'(c == 16)} : 9'b0;
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL single c=%0d got=%b exp=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    logic [2:0] pend;
    logic [3:0] ec;
    do_reset();
    bus.req = 1'b1;
    for (int c = 1; c <= 49; c++) begin
      @(negedge clk);
      bus.req = (c < 3);
      ec   = ((((c - 1) / 16) % 2) == 0) ? A : B;
      pend = (c == 1) ? 3'd1 : (c == 2) ? 3'd2 : (c <= 16) ? 3'd3 : (c <= 32) ? 3'd2 : 3'd1;
      exp  = (c <= 48) ? {1'b1, ec, pend, 1'((c % 16) == 0)} : 9'b0;
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL back_to_back c=%0d got=%b exp=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_close_during_slot();
    logic [8:0] exp;
    logic [2:0] pend;
    do_reset();
    bus.req = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      pend = (c == 1) ? 3'd1 : (c <= 16) ? 3'd2 : 3'd1;
      exp  = (c <= 32) ? {1'b1, A, pend, 1'((c == 16) || (c == 32))} : 9'b0;
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL close_during_slot c=%0d got=%b exp=%b", c, obs, exp);
      end
      bus.req = (c < 2);
      if (c == 3) bus.close_a = 1'b1;
      if (c == 5) bus.close_b = 1'b1;
      if (c == 9) bus.close_a = 1'b0;
    end
    bus.close_b = 1'b0;
  endtask

  task automatic test_wait();
    logic [8:0] exp;
    do_reset();
    bus.close_a = 1'b1; bus.close_b = 1'b1; bus.req = 1'b1;
    for (int c = 1; c <= 37; c++) begin
      @(negedge clk);
      if (c <= 16)      exp = {1'b1, W, 3'd1, 1'b0};
      else if (c == 17) exp = {1'b0, 4'b0, 3'd1, 1'b0};
      else if (c <= 20) exp = {1'b1, W, 3'd1, 1'b0};
      else if (c <= 36) exp = {1'b1, B, 3'd1, 1'(c == 36)};
      else              exp = 9'b0;
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL wait c=%0d got=%b exp=%b", c, obs, exp);
      end
      bus.req = 1'b0;
      if (c == 20) bus.close_b = 1'b0;
    end
    bus.close_a = 1'b0;
  endtask

  task automatic test_full_and_coincide();
    logic [10:0] got, exp;
    logic [2:0]  pend;
    do_reset();
    bus.req = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      pend = (c < 4) ? 3'(c) : 3'd4;
      exp  = {1'b1, (c <= 16) ? A : B, pend, 1'(c == 16), 1'(c == 5), 1'(c < 4)};
      got  = {obs, bus.drop, bus.req_ready};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL full_coincide c=%0d got=%b exp=%b", c, got, exp);
      end
      bus.req = (c < 5) || (c == 16);
    end
    bus.req = 1'b0;
  endtask

  task automatic test_reset_mid_slot();
    do_reset();
    bus.req = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      bus.req = (c < 2);
    end
    checks++;
    if (obs !== {1'b1, B, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL mid_slot_pre got=%b exp=%b", obs, {1'b1, B, 3'd1, 1'b0});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({obs, bus.drop} !== 10'b0) begin
      failures++;
      $display("FAIL mid_slot_reset got=%b exp=%b", {obs, bus.drop}, 10'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 9'b0) begin
      failures++;
      $display("FAIL mid_slot_idle got=%b exp=%b", obs, 9'b0);
    end
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    checks++;
    if (obs !== {1'b1, A, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL mid_slot_regrant got=%b exp=%b", obs, {1'b1, A, 3'd1, 1'b0});
    end
  endtask

  initial begin
    bus.req = 1'b0; bus.close_a = 1'b0; bus.close_b = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_close_during_slot();
    test_wait();
    test_full_and_coincide();
    test_reset_mid_slot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/runway_dispatch.md
RUNWAY_DISPATCH -- requirements
Module: runway_dispatch

Interface
REQ-001 Parameter HOLD, default 16, meaning cycles a runway code is held on the bus per landing (2..16).
REQ-002 Parameter DEPTH, default 4, meaning maximum pending landing requests (1..7).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  1  one-cycle landing request pulse from approach control.
REQ-006 close_a  input  1  runway A closed (level).
REQ-007 close_b  input  1  runway B closed (level).
REQ-008 o3,o2,o1,o0  output  1 each  runway command code, o3 = MSB.
REQ-009 en  output  1  code-valid strobe for the runway status receiver.
REQ-010 pending  output  3  current count of queued requests.
REQ-011 req_ready  output  1  high when pending < DEPTH.
REQ-012 done  output  1  one-cycle pulse when a landing slot completes.
REQ-013 drop  output  1  one-cycle pulse when a req is discarded because the queue is full.

Function
REQ-014 Codes: A = 1010, B = 1011, WAIT = 1101, idle = 0000; no other code SHALL ever be driven.
REQ-015 FSM states: IDLE, SEND_A, SEND_B, SEND_W; outputs registered.
REQ-016 IDLE: en=0, code 0000; on pending>0, go to SEND_A/SEND_B per REQ-017, or SEND_W if both runways are closed.
REQ-017 Runway choice: round-robin via a last-used flag; prefer the runway not last used if it is open, else the other if it is open; last-used resets to B, so the first grant is A.
REQ-018 SEND_A/SEND_B: en=1, code held constant for exactly HOLD consecutive cycles, counted by a 4-bit hold counter starting at 0.
REQ-019 On the last hold cycle: done=1, pending decrements, last-used updates; next state follows REQ-016 using the decremented pending.
REQ-020 Back-to-back grants: the next code SHALL follow on the next cycle with no idle gap.
REQ-021 close_a/close_b changing during SEND_A/SEND_B SHALL NOT abort or shorten the slot.
REQ-022 SEND_W: en=1, code WAIT, evaluated every cycle; on the first cycle either runway is open, move to that runway's SEND state with the hold counter cleared. WAIT cycles SHALL NOT decrement pending or pulse done.
REQ-023 SEND_W held HOLD cycles without resolution: drop en and code to 0000 for one cycle, then re-enter SEND_W, so the receiver's wait counter re-arms.
REQ-024 Queue: req with pending<DEPTH increments pending; req with pending=DEPTH leaves pending unchanged and pulses drop.
REQ-025 Simultaneous req and slot completion: pending unchanged, no drop even when full.
REQ-026 pending SHALL never exceed DEPTH nor underflow below 0.
REQ-027 req_ready is combinational from pending.

Reset
REQ-028 rst=1 at a clock edge: state IDLE, hold counter 0, pending 0, last-used B, en 0, code 0000, done 0, drop 0; any in-progress slot is abandoned, with no done pulse.
REQ-029 req asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-030 Single req, both runways open: en=1 with code 1010 for 16 cycles starting the cycle after req, done pulse on the 16th cycle, then 0000/en=0.
REQ-031 Three reqs on consecutive cycles: codes 1010 x16, 1011 x16, 1010 x16 with no gaps; pending sequence 1,2,3 then decrements at each done; three done pulses.
REQ-032 close_a=1 and close_b=1, one req: WAIT 1101 for 16 cycles, one cycle of 0000, WAIT again; deassert close_b and the next cycle drives 1011 for 16 cycles, then done.
REQ-033 Five reqs back-to-back with DEPTH=4 while a slot is active: pending saturates at 4, drop pulses once, req_ready=0 while full.
REQ-034 With pending=4, req coincides with a done: pending stays 4 and drop stays 0.
REQ-035 rst asserted on hold cycle 7 of SEND_B: next cycle en=0, code 0000, pending 0, no done; after release, the next req is granted runway A.
